spin_controller: RTL and testbench
==================================

Name: spin_controller

Overview:
- Consumes the 4-bit pseudo-random stream from the LFSR and runs one three-reel spin per request.
- Samples one random value per reel and reduces each to a symbol index.
- Steps the reels at a visible rate and stops them staggered on their targets.
- Reports the final symbols plus jackpot/pair flags to the display and payout logic downstream.

Parameters:
- NUM_SYMBOLS, 8: symbols per reel; legal range 8..16.
- TICK_DIV, 2500000: clk cycles per reel step tick (50 MHz, 20 Hz). Benches use 1.
- MIN_STEPS, 8: minimum advances before reel i may stop, scaled by (i+1): 8, 16, 24.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- rnd_in  in  4  random value from LFSR output randomnumber.
- spin  in  1  spin request, level-sampled each clk; accepted only in IDLE.
- busy  out  1  high from accept until DONE exits.
- done  out  1  one-cycle pulse when all reels have stopped.
- reel0_pos, reel1_pos, reel2_pos  out  4 each  current symbol of each reel.
- reel_stopped  out  3  bit i high when reel i has stopped in the current/last spin.
- jackpot  out  1  all three final symbols equal.
- pair  out  1  exactly two final symbols equal.

Behaviour:
- Reset values:
  - state IDLE; busy=0, done=0, jackpot=0, pair=0.
  - reel_stopped=3'b111; all reel positions 0.
  - targets, step counters and prescaler 0.
- Reel positions persist across spins; only reset clears them.
- FSM states: IDLE, SAMPLE, SPIN, DONE.
- IDLE, spin=1:
  - go to SAMPLE; busy=1.
  - jackpot, pair and reel_stopped cleared to 0.
  - step counters and prescaler cleared to 0.
- SAMPLE (3 cycles):
  - cycle k (k=0,1,2) captures target[k] = rnd_in reduced mod NUM_SYMBOLS.
  - Reduction is a single conditional subtract: rnd_in >= NUM_SYMBOLS ? rnd_in - NUM_SYMBOLS : rnd_in.
  - After cycle 2, go to SPIN.
- SPIN:
  - Prescaler counts 0..TICK_DIV-1; a tick fires when it wraps.
  - On each tick, for each reel i with reel_stopped[i]=0:
    - if step_cnt[i] >= MIN_STEPS*(i+1) and pos[i]==target[i]: set reel_stopped[i] and do not advance;
    - else pos[i] = (pos[i]==NUM_SYMBOLS-1) ? 0 : pos[i]+1, and step_cnt[i] increments.
  - When reel_stopped==3'b111 (registered), go to DONE.
- DONE (1 cycle):
  - done=1.
  - jackpot and pair computed from final positions and held until the next accept.
  - Next state IDLE; busy drops when DONE exits.
- spin while busy: ignored and not queued.
- spin held high continuously: a new spin is accepted in the first IDLE cycle after DONE.
- Step counter width covers MIN_STEPS*3 + NUM_SYMBOLS without overflow.
- Stop order is structurally reel0 then reel1 then reel2; ties across reels on the same tick are legal.
- Reset mid-spin: immediate return to the reset values; no done pulse.

Optional Feature:
- Macro FORCE_TARGET_EN.
- Defined:
  - adds inputs force_en (1 bit) and force_sym (4 bits);
  - in SAMPLE, if force_en=1, target[k] = force_sym reduced mod NUM_SYMBOLS instead of rnd_in. Used for demo and verification.
- Undefined: ports absent; targets come only from rnd_in.

Decomposition:
- Package spin_pkg holds:
  - state enum (IDLE, SAMPLE, SPIN, DONE);
  - NUM_REELS=3;
  - SYM_W=4;
  - the mod-reduction function.
- Sub-module reel_unit holds one reel's position, target, step counter and stop logic, with inputs tick, load_target, clear and REEL_IDX. spin_controller instantiates it three times.

Test Plan:
- Reset mid-SPIN -> busy=0, done=0, reel_stopped=3'b111, all positions 0 on the same edge.
- NUM_SYMBOLS=8, TICK_DIV=1, from reset; spin=1 for one cycle; rnd_in=5,13,2 on the three SAMPLE cycles -> targets 5,5,2.
  - Reels stop after 13, 21 and 26 advances.
  - Final positions 5,5,2; done pulses once; pair=1, jackpot=0.
- rnd_in=3,11,3 -> targets 3,3,3 -> jackpot=1, pair=0.
- rnd_in=1,2,4 -> jackpot=0, pair=0.
- spin pulsed during SAMPLE and SPIN -> no restart; exactly one done pulse.
- Second spin without reset -> positions start from previous finals; the step-minimum rule still holds per reel.
- TICK_DIV=4 -> positions change only every 4th clk.
- Wrap check: position 7 -> 0 on NUM_SYMBOLS=8.
- FORCE_TARGET_EN defined, force_en=1, force_sym=12 -> all targets 4 -> jackpot=1.

Source files
------------

// File: rtl/spin_controller_pkg.sv
// Shared types and helpers for the three-reel spin controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spin_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        SPIN   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_REELS = 3;
    localparam int SYM_W     = 4;

    // A single conditional subtract is enough: a 4-bit value is below 16 and
    // NUM_SYMBOLS is at least 8, so the result always lands in 0..NUM_SYMBOLS-1.
    function automatic logic [SYM_W-1:0] mod_sym(input logic [SYM_W-1:0] v,
                                                 input int num_symbols);
        logic [SYM_W-1:0] r;
        r = v;
        if (int'(v) >= num_symbols) begin
            r = SYM_W'(int'(v) - num_symbols);
        end
        return r;
    endfunction

endpackage

// File: rtl/spin_controller_if.sv
// Request/result bundle between the spin controller and its surroundings.
// Latency: n/a (wiring only).
// Backpressure: none; spin is a level request, ignored while busy.
// Ports: rnd_in/spin (and force_en/force_sym when FORCE_TARGET_EN is defined)
// go into the controller; busy/done/reel positions/reel_stopped/jackpot/pair
// come out of it.
interface spin_controller_if;
    import spin_pkg::*;

    logic [SYM_W-1:0]     rnd_in;
    logic                 spin;
`ifdef FORCE_TARGET_EN
    logic                 force_en;
    logic [SYM_W-1:0]     force_sym;
`endif
    logic                 busy;
    logic                 done;
    logic [SYM_W-1:0]     reel0_pos;
    logic [SYM_W-1:0]     reel1_pos;
    logic [SYM_W-1:0]     reel2_pos;
    logic [NUM_REELS-1:0] reel_stopped;
    logic                 jackpot;
    logic                 pair;

`ifdef FORCE_TARGET_EN
    modport master (output rnd_in, spin, force_en, force_sym,
                    input  busy, done, reel0_pos, reel1_pos, reel2_pos,
                           reel_stopped, jackpot, pair);
    modport slave  (input  rnd_in, spin, force_en, force_sym,
                    output busy, done, reel0_pos, reel1_pos, reel2_pos,
                           reel_stopped, jackpot, pair);
`else
    modport master (output rnd_in, spin,
                    input  busy, done, reel0_pos, reel1_pos, reel2_pos,
                           reel_stopped, jackpot, pair);
    modport slave  (input  rnd_in, spin,
                    output busy, done, reel0_pos, reel1_pos, reel2_pos,
                           reel_stopped, jackpot, pair);
`endif

endinterface

// File: rtl/spin_controller_reel_unit.sv
// One reel: position, target, step counter and stop decision.
// Latency: position/stop update on the clk edge where tick_i is high.
// Backpressure: none; a stopped reel simply ignores further ticks.
// Ports: clk, rst, tick_i, load_target_i, clear_i, target_i -> pos_o, stopped_o.
module reel_unit
    import spin_pkg::*;
#(
    parameter int NUM_SYMBOLS = 8,
    parameter int MIN_STEPS   = 8,
    parameter int REEL_IDX    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             load_target_i,
    input  logic             clear_i,
    input  logic [SYM_W-1:0] target_i,
    output logic [SYM_W-1:0] pos_o,
    output logic             stopped_o
);

    // Worst case the counter reaches MIN_CNT + NUM_SYMBOLS - 1 before the
    // target comes round again.
    localparam int CNT_W   = $clog2(MIN_STEPS * 3 + NUM_SYMBOLS + 1);
    localparam int MIN_CNT = MIN_STEPS * (REEL_IDX + 1);

    logic [SYM_W-1:0] pos_q, pos_d;
    logic [SYM_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stopped_q, stopped_d;

    always_comb begin
        pos_d     = pos_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        stopped_d = stopped_q;
        if (clear_i) begin
            cnt_d     = '0;
            stopped_d = 1'b0;
        end
        if (load_target_i) begin
            target_d = target_i;
        end
        if (tick_i && !stopped_q) begin
            if ((cnt_q >= CNT_W'(MIN_CNT)) && (pos_q == target_q)) begin
                stopped_d = 1'b1;
            end else begin
                pos_d = (pos_q == SYM_W'(NUM_SYMBOLS - 1)) ? '0 : pos_q + 1'b1;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q     <= '0;
            target_q  <= '0;
            cnt_q     <= '0;
            stopped_q <= 1'b1;
        end else begin
            pos_q     <= pos_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            stopped_q <= stopped_d;
        end
    end

    assign pos_o     = pos_q;
    assign stopped_o = stopped_q;

endmodule

// File: rtl/spin_controller.sv
// Three-reel spin controller: samples targets from the LFSR stream, steps reels, reports result.
// Latency: accept, 3 sample cycles, SPIN until all reels stop, then a 1-cycle done pulse.
// Backpressure: spin is only accepted in IDLE; requests while busy are dropped, not queued.
// Ports: clk, reset (async active-high), bus (slave side of spin_controller_if).
// Optional: FORCE_TARGET_EN adds force_en/force_sym to override sampled targets.
module spin_controller
    import spin_pkg::*;
#(
    parameter int NUM_SYMBOLS = 8,
    parameter int TICK_DIV    = 2500000,
    parameter int MIN_STEPS   = 8
) (
    input  logic               clk,
    input  logic               reset,
    spin_controller_if.slave   bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t                state_q, state_d;
    logic [1:0]            samp_q, samp_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic                  jackpot_q, jackpot_d;
    logic                  pair_q, pair_d;

    logic                  accept;
    logic                  tick;
    logic [SYM_W-1:0]      samp_src;
    logic [SYM_W-1:0]      target_sym;
    logic [SYM_W-1:0]      pos [NUM_REELS];
    logic [NUM_REELS-1:0]  stopped;
    logic                  eq01, eq12, eq02;

    assign accept = (state_q == IDLE) && bus.spin;
    assign tick   = (state_q == SPIN) && (presc_q == PW'(TICK_DIV - 1));

`ifdef FORCE_TARGET_EN
    assign samp_src = bus.force_en ? bus.force_sym : bus.rnd_in;
`else
    assign samp_src = bus.rnd_in;
`endif
    assign target_sym = mod_sym(samp_src, NUM_SYMBOLS);

    for (genvar k = 0; k < NUM_REELS; k++) begin : g_reel
        reel_unit #(
            .NUM_SYMBOLS (NUM_SYMBOLS),
            .MIN_STEPS   (MIN_STEPS),
            .REEL_IDX    (k)
        ) u_reel (
            .clk           (clk),
            .rst           (reset),
            .tick_i        (tick),
            .load_target_i ((state_q == SAMPLE) && (samp_q == 2'(k))),
            .clear_i       (accept),
            .target_i      (target_sym),
            .pos_o         (pos[k]),
            .stopped_o     (stopped[k])
        );
    end

    assign eq01 = (pos[0] == pos[1]);
    assign eq12 = (pos[1] == pos[2]);
    assign eq02 = (pos[0] == pos[2]);

    always_comb begin
        state_d   = state_q;
        samp_d    = samp_q;
        presc_d   = presc_q;
        jackpot_d = jackpot_q;
        pair_d    = pair_q;
        case (state_q)
            IDLE: begin
                if (bus.spin) begin
                    state_d   = SAMPLE;
                    samp_d    = '0;
                    presc_d   = '0;
                    jackpot_d = 1'b0;
                    pair_d    = 1'b0;
                end
            end
            SAMPLE: begin
                samp_d = samp_q + 1'b1;
                if (samp_q == 2'd2) begin
                    state_d = SPIN;
                end
            end
            SPIN: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                // Flags are latched on the way into DONE so they are already
                // valid while the done pulse is high.
                if (&stopped) begin
                    state_d   = DONE;
                    jackpot_d = eq01 && eq12;
                    pair_d    = (eq01 || eq12 || eq02) && !(eq01 && eq12);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            samp_q    <= '0;
            presc_q   <= '0;
            jackpot_q <= 1'b0;
            pair_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            samp_q    <= samp_d;
            presc_q   <= presc_d;
            jackpot_q <= jackpot_d;
            pair_q    <= pair_d;
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = (state_q == DONE);
    assign bus.reel0_pos    = pos[0];
    assign bus.reel1_pos    = pos[1];
    assign bus.reel2_pos    = pos[2];
    assign bus.reel_stopped = stopped;
    assign bus.jackpot      = jackpot_q;
    assign bus.pair         = pair_q;

endmodule

// File: tb/tb_spin_controller.sv
// Directed bench for spin_controller: one instance with TICK_DIV=1, one with TICK_DIV=4.
// Latency: expected done latencies are hand-computed per spin.
// Backpressure: exercises spin pokes while busy and spin held high across DONE.
module tb_spin_controller;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    spin_controller_if i1 ();
    spin_controller_if i4 ();

    spin_controller #(.NUM_SYMBOLS(8), .TICK_DIV(1), .MIN_STEPS(8)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (i1)
    );

    spin_controller #(.NUM_SYMBOLS(8), .TICK_DIV(4), .MIN_STEPS(8)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (i4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    // Runs one spin on dut1. Edge E0 accepts, E1..E3 sample a,b,c, and the
    // done pulse is expected right after edge E<exp_lat>.
    task automatic run_spin(input string nm,
                            input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            input int exp_lat,
                            input logic [3:0] e0, input logic [3:0] e1, input logic [3:0] e2,
                            input logic ejp, input logic epr,
                            input logic poke, input logic hold);
        int first_done;
        int ndone;
        first_done = -1;
        ndone      = 0;
        i1.spin = 1'b1;
        step();                                   // E0
        i1.spin = hold;
        chk({nm, "_accept_busy"}, 32'(i1.busy), 1);
        chk({nm, "_accept_stopped"}, 32'(i1.reel_stopped), 0);
        i1.rnd_in = a;
        step();                                   // E1
        i1.rnd_in = b;
        if (poke) i1.spin = 1'b1;
        step();                                   // E2
        i1.rnd_in = c;
        i1.spin = hold;
        step();                                   // E3
        for (int n = 4; n <= exp_lat + 2; n++) begin
            if (poke) i1.spin = (n == 5) || (n == 20);
            step();
            if (i1.done) begin
                ndone++;
                if (first_done < 0) first_done = n;
            end
            if (n == exp_lat) begin
                chk({nm, "_done"}, 32'(i1.done), 1);
                chk({nm, "_pos0"}, 32'(i1.reel0_pos), 32'(e0));
                chk({nm, "_pos1"}, 32'(i1.reel1_pos), 32'(e1));
                chk({nm, "_pos2"}, 32'(i1.reel2_pos), 32'(e2));
                chk({nm, "_jackpot"}, 32'(i1.jackpot), 32'(ejp));
                chk({nm, "_pair"}, 32'(i1.pair), 32'(epr));
                chk({nm, "_stopped"}, 32'(i1.reel_stopped), 7);
            end
            if (n == exp_lat + 1) begin
                chk({nm, "_idle_busy"}, 32'(i1.busy), 0);
                chk({nm, "_idle_done"}, 32'(i1.done), 0);
                chk({nm, "_held_jackpot"}, 32'(i1.jackpot), 32'(ejp));
            end
            if (n == exp_lat + 2) begin
                chk({nm, "_reaccept_busy"}, 32'(i1.busy), 32'(hold));
            end
        end
        chk({nm, "_done_latency"}, 32'(first_done), 32'(exp_lat));
        chk({nm, "_done_count"}, 32'(ndone), 1);
        i1.spin = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        i1.spin   = 1'b0;
        i1.rnd_in = '0;
        i4.spin   = 1'b0;
        i4.rnd_in = '0;
`ifdef FORCE_TARGET_EN
        i1.force_en  = 1'b0;
        i1.force_sym = '0;
        i4.force_en  = 1'b0;
        i4.force_sym = '0;
`endif
        #12;
        chk("rst_busy", 32'(i1.busy), 0);
        chk("rst_done", 32'(i1.done), 0);
        chk("rst_jackpot", 32'(i1.jackpot), 0);
        chk("rst_pair", 32'(i1.pair), 0);
        chk("rst_stopped", 32'(i1.reel_stopped), 7);
        chk("rst_pos", 32'({i1.reel0_pos, i1.reel1_pos, i1.reel2_pos}), 0);
        chk("rst4_stopped", 32'(i4.reel_stopped), 7);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Targets 5,5,2 from 0: stops after 13/21/26 advances, 27 ticks.
        run_spin("s1", 4'd5, 4'd13, 4'd2, 31, 4'd5, 4'd5, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        // From 5,5,2 with targets 3,3,3: advances 14/22/25, 26 ticks.
        run_spin("s2", 4'd3, 4'd11, 4'd3, 30, 4'd3, 4'd3, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        // From 3,3,3 with targets 1,2,4: advances 14/23/25; spin poked while busy.
        run_spin("s3", 4'd1, 4'd2, 4'd4, 30, 4'd1, 4'd2, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);

        // TICK_DIV=4: reel0 moves on edges 7, 11, ... and wraps 7->0 on edge 35.
        i4.spin = 1'b1;
        step();
        i4.spin   = 1'b0;
        i4.rnd_in = 4'd7;
        step();
        step();
        step();
        for (int n = 4; n <= 40; n++) begin
            step();
            if (n == 6)  chk("div4_pos_e6", 32'(i4.reel0_pos), 0);
            if (n == 7)  chk("div4_pos_e7", 32'(i4.reel0_pos), 1);
            if (n == 10) chk("div4_pos_e10", 32'(i4.reel0_pos), 1);
            if (n == 11) chk("div4_pos_e11", 32'(i4.reel0_pos), 2);
            if (n == 34) chk("wrap_pos7", 32'(i4.reel0_pos), 7);
            if (n == 35) chk("wrap_pos0", 32'(i4.reel0_pos), 0);
        end
        chk("mid_busy", 32'(i4.busy), 1);
        chk("mid_stopped", 32'(i4.reel_stopped), 0);
        chk("mid_pos0", 32'(i4.reel0_pos), 1);
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(i4.busy), 0);
        chk("midrst_done", 32'(i4.done), 0);
        chk("midrst_stopped", 32'(i4.reel_stopped), 7);
        chk("midrst_pos", 32'({i4.reel0_pos, i4.reel1_pos, i4.reel2_pos}), 0);
        chk("midrst_dut1_pos0", 32'(i1.reel0_pos), 0);
        @(negedge clk);
        reset = 1'b0;
        step();

`ifdef FORCE_TARGET_EN
        // force_sym 12 reduces to 4 for every reel: advances 12/20/28, 29 ticks.
        i1.force_en  = 1'b1;
        i1.force_sym = 4'd12;
        run_spin("force", 4'd1, 4'd2, 4'd3, 33, 4'd4, 4'd4, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        i1.force_en = 1'b0;
        do_reset();
`endif

        // Spin held high: targets 5,5,5 from 0, advances 13/21/29, 30 ticks,
        // and a new spin is accepted in the IDLE cycle right after DONE.
        run_spin("held", 4'd5, 4'd5, 4'd5, 34, 4'd5, 4'd5, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        do_reset();
        chk("final_busy", 32'(i1.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
